alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Multi-cycle signed ALU, the successor to the team's combinational 8-bit ALU. It adds a valid/ready handshake on both sides, registered results and flags, iterative multiply/divide/remainder, and overflow and divide-by-zero status. Intended to sit between the register file / operand bus and the writeback stage of the teaching CPU datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>= 4).
W_ALU_SEL, 3, opcode width (localparam, fixed).

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
s_valid  input  1  operands/opcode valid
s_ready  output  1  block can accept an operation
bus_a  input  WIDTH  signed operand A
bus_b  input  WIDTH  signed operand B
alu_sel  input  3  opcode
m_valid  output  1  result valid
m_ready  input  1  consumer accepts result
alu_out  output  WIDTH  signed result (registered)
zero  output  1  alu_out == 0 (registered)
negative  output  1  alu_out[WIDTH-1] (registered)
overflow  output  1  signed overflow of the operation (registered)
div_by_zero  output  1  div/rem with bus_b == 0 (registered)

Behaviour:
- Reset is asynchronous, active-low, and applies mid-operation:
  - state = IDLE; m_valid, alu_out, zero, negative, overflow, div_by_zero = 0; internal counter and accumulators cleared.
  - s_ready reads 1 in IDLE; inputs are ignored while rstn is low.
- Opcodes:
  - 000 pass a; 001 a+b; 010 a-b; 011 a*b (low WIDTH bits).
  - 100 a/2, truncating toward zero (-3/2 = -1).
  - 101 a/b, truncating toward zero; 110 a%b, sign follows a; 111 pass a.
- Accept: on the edge where s_valid && s_ready. Operands and opcode are captured; they need not be held afterwards.
- s_ready = (state==IDLE) || (state==DONE && m_ready). This gives back-to-back acceptance as a result drains.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> DONE on accept of a single-cycle op (000/001/010/100/111), or of 101/110 with b==0.
  - IDLE -> BUSY on accept of 011, or of 101/110 with b!=0.
  - BUSY -> DONE after exactly WIDTH iteration cycles (counter WIDTH-1 down to 0).
  - DONE -> IDLE on m_ready without a new accept; DONE -> DONE/BUSY on m_ready with a simultaneous accept.
- Latency: result, flags and m_valid update together.
  - Single-cycle ops: 1 edge after accept.
  - mul/div/rem: WIDTH+1 edges after accept.
- Iterative engine: operates on magnitudes; sign is fixed up in the final cycle.
  - mul: shift-add, 2*WIDTH-bit product.
  - div/rem: restoring division, one quotient bit per cycle.
- Overflow rules:
  - add/sub: standard signed overflow (operand signs vs result sign).
  - mul: full 2*WIDTH product not representable in WIDTH bits.
  - div: MIN / -1 gives alu_out = MIN, overflow = 1; rem of MIN % -1 gives 0, overflow = 0.
  - All other ops: overflow = 0.
- Divide by zero: alu_out = all ones (-1) for 101, alu_out = a for 110; div_by_zero = 1, overflow = 0.
- Backpressure: while m_valid && !m_ready, alu_out and all flags are held stable and s_ready = 0.
- Outputs and flags hold their last values after the handshake until the next result loads. m_valid drops the cycle after handshake unless a new single-cycle result loads on the same edge.
- Arithmetic wraps modulo 2^WIDTH. zero and negative are derived from the registered alu_out.

Test Plan:
1. WIDTH=8, add 100+50 -> alu_out=-106 (0x96), overflow=1, negative=1, m_valid 1 edge after accept; sub 5-5 -> 0, zero=1.
2. mul -7*9 -> -63, overflow=0, m_valid exactly 9 edges after accept with s_ready=0 throughout; mul 16*16 -> 0, overflow=1, zero=1.
3. div -7/2 -> -3; rem -7%2 -> -1; op100 a=-3 -> -1; div -128/-1 -> -128, overflow=1; each mul/div/rem with latency 9.
4. div 5/0 -> alu_out=-1, div_by_zero=1, latency 1; rem 5%0 -> 5, div_by_zero=1.
5. Hold m_ready=0 for 5 cycles after a result -> alu_out/flags stable, s_ready=0, pulses on s_valid ignored; then m_ready=1 with s_valid=1 add 1+2 -> next edge alu_out=3, m_valid stays high.
6. Assert rstn low in the 4th BUSY cycle of a mul -> all outputs 0 immediately, state IDLE; after release, add 3+4 -> 7 with latency 1.

Source files
------------

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle signed ALU with valid/ready handshake and iterative mul/div/rem
module alu_mc #(
  parameter int WIDTH = 8,
  localparam int W_ALU_SEL = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     bus_a,
  input  logic [WIDTH-1:0]     bus_b,
  input  logic [W_ALU_SEL-1:0] alu_sel,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     alu_out,
  output logic                 zero,
  output logic                 negative,
  output logic                 overflow,
  output logic                 div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_op;
  logic                 r_neg;      // sign of the final mul product / quotient
  logic                 r_neg_a;    // sign of the dividend, applied to the remainder
  logic                 r_special;  // MIN / -1 quotient overflow
  logic [2*WIDTH-1:0]   r_acc;      // mul: product; div: partial remainder in low WIDTH+1 bits
  logic [2*WIDTH-1:0]   r_opx;      // mul: shifting multiplicand; div: divisor in low bits
  logic [WIDTH-1:0]     r_opy;      // mul: shifting multiplier; div: dividend / quotient
  logic                 r_m_valid;
  logic [WIDTH-1:0]     r_alu_out;
  logic                 r_zero, r_negative, r_overflow, r_dbz;

  logic                 w_accept;
  logic                 w_is_multi;
  logic [WIDTH-1:0]     w_abs_a, w_abs_b, w_sum, w_diff, w_tmp, w_sc_res;
  logic                 w_sc_ovf, w_sc_dbz;
  logic [2*WIDTH-1:0]   w_mul_acc_nxt, w_prod_s;
  logic [WIDTH:0]       w_div_shift, w_div_rem_nxt;
  logic                 w_div_ge;
  logic [WIDTH-1:0]     w_div_quo_nxt, w_fin_res;
  logic                 w_fin_ovf;

  assign s_ready     = (r_state == IDLE) || ((r_state == DONE) && m_ready);
  assign w_accept    = s_valid && s_ready;
  assign m_valid     = r_m_valid;
  assign alu_out     = r_alu_out;
  assign zero        = r_zero;
  assign negative    = r_negative;
  assign overflow    = r_overflow;
  assign div_by_zero = r_dbz;

  // Decode the incoming op: single-cycle result and flags, or whether it needs the iterative engine
  always_comb begin
    w_abs_a    = bus_a[WIDTH-1] ? (~bus_a + 1'b1) : bus_a;
    w_abs_b    = bus_b[WIDTH-1] ? (~bus_b + 1'b1) : bus_b;
    w_sum      = bus_a + bus_b;
    w_diff     = bus_a - bus_b;
    // bias negative values by one so the arithmetic shift truncates toward zero
    w_tmp      = bus_a + {{(WIDTH-1){1'b0}}, bus_a[WIDTH-1]};
    w_sc_res   = bus_a;
    w_sc_ovf   = 1'b0;
    w_sc_dbz   = 1'b0;
    w_is_multi = 1'b0;
    case (alu_sel)
      3'b001: begin
        w_sc_res = w_sum;
        w_sc_ovf = (bus_a[WIDTH-1] == bus_b[WIDTH-1]) && (w_sum[WIDTH-1] != bus_a[WIDTH-1]);
      end
      3'b010: begin
        w_sc_res = w_diff;
        w_sc_ovf = (bus_a[WIDTH-1] != bus_b[WIDTH-1]) && (w_diff[WIDTH-1] != bus_a[WIDTH-1]);
      end
      3'b011: w_is_multi = 1'b1;
      3'b100: w_sc_res = {w_tmp[WIDTH-1], w_tmp[WIDTH-1:1]};
      3'b101, 3'b110: begin
        if (bus_b == '0) begin
          w_sc_res = (alu_sel == 3'b101) ? {WIDTH{1'b1}} : bus_a;
          w_sc_dbz = 1'b1;
        end else begin
          w_is_multi = 1'b1;
        end
      end
      default: w_sc_res = bus_a;
    endcase
  end

  // One iteration of shift-add multiply / restoring divide, plus the sign-fixed final result
  always_comb begin
    w_mul_acc_nxt = r_acc + (r_opy[0] ? r_opx : '0);
    w_prod_s      = r_neg ? (~w_mul_acc_nxt + 1'b1) : w_mul_acc_nxt;
    w_div_shift   = {r_acc[WIDTH-1:0], r_opy[WIDTH-1]};
    w_div_ge      = w_div_shift >= {1'b0, r_opx[WIDTH-1:0]};
    w_div_rem_nxt = w_div_ge ? (w_div_shift - {1'b0, r_opx[WIDTH-1:0]}) : w_div_shift;
    w_div_quo_nxt = {r_opy[WIDTH-2:0], w_div_ge};
    w_fin_res     = w_prod_s[WIDTH-1:0];
    w_fin_ovf     = 1'b0;
    case (r_op)
      3'b011: begin
        w_fin_res = w_prod_s[WIDTH-1:0];
        w_fin_ovf = !((&w_prod_s[2*WIDTH-1:WIDTH-1]) || (~|w_prod_s[2*WIDTH-1:WIDTH-1]));
      end
      3'b101: begin
        w_fin_res = r_neg ? (~w_div_quo_nxt + 1'b1) : w_div_quo_nxt;
        w_fin_ovf = r_special;
      end
      default: w_fin_res = r_neg_a ? (~w_div_rem_nxt[WIDTH-1:0] + 1'b1) : w_div_rem_nxt[WIDTH-1:0];
    endcase
  end

  // Control FSM, iterative datapath and registered result/flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_neg      <= 1'b0;
      r_neg_a    <= 1'b0;
      r_special  <= 1'b0;
      r_acc      <= '0;
      r_opx      <= '0;
      r_opy      <= '0;
      r_m_valid  <= 1'b0;
      r_alu_out  <= '0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_overflow <= 1'b0;
      r_dbz      <= 1'b0;
    end else if (w_accept) begin
      r_op <= alu_sel;
      if (w_is_multi) begin
        r_state   <= BUSY;
        r_m_valid <= 1'b0;
        r_cnt     <= CW'(WIDTH-1);
        r_acc     <= '0;
        r_neg     <= bus_a[WIDTH-1] ^ bus_b[WIDTH-1];
        r_neg_a   <= bus_a[WIDTH-1];
        r_special <= (alu_sel == 3'b101) && (bus_a == MIN_VAL) && (&bus_b);
        if (alu_sel == 3'b011) begin
          r_opx <= {{WIDTH{1'b0}}, w_abs_a};
          r_opy <= w_abs_b;
        end else begin
          r_opx <= {{WIDTH{1'b0}}, w_abs_b};
          r_opy <= w_abs_a;
        end
      end else begin
        r_state    <= DONE;
        r_m_valid  <= 1'b1;
        r_alu_out  <= w_sc_res;
        r_zero     <= (w_sc_res == '0);
        r_negative <= w_sc_res[WIDTH-1];
        r_overflow <= w_sc_ovf;
        r_dbz      <= w_sc_dbz;
      end
    end else begin
      case (r_state)
        BUSY: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_op == 3'b011) begin
            r_acc <= w_mul_acc_nxt;
            r_opx <= r_opx << 1;
            r_opy <= r_opy >> 1;
          end else begin
            r_acc <= {{(WIDTH-1){1'b0}}, w_div_rem_nxt};
            r_opy <= w_div_quo_nxt;
          end
          if (r_cnt == '0) begin
            r_state    <= DONE;
            r_m_valid  <= 1'b1;
            r_alu_out  <= w_fin_res;
            r_zero     <= (w_fin_res == '0);
            r_negative <= w_fin_res[WIDTH-1];
            r_overflow <= w_fin_ovf;
            r_dbz      <= 1'b0;
          end
        end
        DONE: begin
          if (m_ready) begin
            r_state   <= IDLE;
            r_m_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed self-checking bench for alu_mc
module tb_alu_mc;

  logic       clk = 1'b0;
  logic       rstn;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] bus_a, bus_b;
  logic [2:0] alu_sel;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] alu_out;
  logic       zero, negative, overflow, div_by_zero;

  int n_cmp = 0;
  int n_fail = 0;

  alu_mc #(.WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
    .bus_a(bus_a), .bus_b(bus_b), .alu_sel(alu_sel),
    .m_valid(m_valid), .m_ready(m_ready), .alu_out(alu_out),
    .zero(zero), .negative(negative), .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Issue one op from IDLE, then count edges (accept edge = 1) until m_valid, bounded at 40
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output bit rdy_busy);
    alu_sel = op; bus_a = a; bus_b = b; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; bus_a = 8'h5A; bus_b = 8'hA5; alu_sel = 3'b001;
    lat = 1; rdy_busy = 1'b0;
    while (!m_valid && lat < 40) begin
      if (s_ready) rdy_busy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    bus_a = 8'h00; bus_b = 8'h00; alu_sel = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (alu_out !== 8'h00) begin n_fail++; $display("FAIL rst_out got %h exp 00", alu_out); end
    n_cmp++; if ({m_valid, zero, negative, overflow, div_by_zero} !== 5'b0) begin
      n_fail++; $display("FAIL rst_flags got %b exp 00000", {m_valid, zero, negative, overflow, div_by_zero}); end
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", s_ready); end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub();
    int lat; bit rb;
    run_op(3'b001, 8'd100, 8'd50, lat, rb);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL add_lat got %0d exp 1", lat); end
    n_cmp++; if (alu_out !== 8'h96) begin n_fail++; $display("FAIL add_out got %h exp 96", alu_out); end
    n_cmp++; if ({overflow, negative, zero} !== 3'b110) begin
      n_fail++; $display("FAIL add_flags got %b exp 110", {overflow, negative, zero}); end
    drain();
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain got %b exp 0", m_valid); end
    n_cmp++; if (alu_out !== 8'h96) begin n_fail++; $display("FAIL add_hold got %h exp 96", alu_out); end
    run_op(3'b010, 8'd5, 8'd5, lat, rb);
    n_cmp++; if (alu_out !== 8'h00 || zero !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL sub_zero got %h z%b v%b exp 00 z1 v0", alu_out, zero, overflow); end
    drain();
  endtask

  task automatic test_mul();
    int lat; bit rb;
    run_op(3'b011, 8'hF9, 8'd9, lat, rb);
    n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL mul_lat got %0d exp 9", lat); end
    n_cmp++; if (rb !== 1'b0) begin n_fail++; $display("FAIL mul_busy_ready got %b exp 0", rb); end
    n_cmp++; if (alu_out !== 8'hC1 || overflow !== 1'b0 || negative !== 1'b1) begin
      n_fail++; $display("FAIL mul_neg got %h v%b n%b exp c1 v0 n1", alu_out, overflow, negative); end
    drain();
    run_op(3'b011, 8'd16, 8'd16, lat, rb);
    n_cmp++; if (alu_out !== 8'h00 || overflow !== 1'b1 || zero !== 1'b1) begin
      n_fail++; $display("FAIL mul_ovf got %h v%b z%b exp 00 v1 z1", alu_out, overflow, zero); end
    drain();
  endtask

  task automatic test_div();
    int lat; bit rb;
    run_op(3'b101, 8'hF9, 8'd2, lat, rb);
    n_cmp++; if (alu_out !== 8'hFD || lat !== 9) begin
      n_fail++; $display("FAIL div_neg got %h lat %0d exp fd lat 9", alu_out, lat); end
    drain();
    run_op(3'b110, 8'hF9, 8'd2, lat, rb);
    n_cmp++; if (alu_out !== 8'hFF || lat !== 9) begin
      n_fail++; $display("FAIL rem_neg got %h lat %0d exp ff lat 9", alu_out, lat); end
    drain();
    run_op(3'b100, 8'hFD, 8'd0, lat, rb);
    n_cmp++; if (alu_out !== 8'hFF || lat !== 1) begin
      n_fail++; $display("FAIL half_neg got %h lat %0d exp ff lat 1", alu_out, lat); end
    drain();
    run_op(3'b101, 8'h80, 8'hFF, lat, rb);
    n_cmp++; if (alu_out !== 8'h80 || overflow !== 1'b1 || lat !== 9) begin
      n_fail++; $display("FAIL div_min got %h v%b lat %0d exp 80 v1 lat 9", alu_out, overflow, lat); end
    drain();
    run_op(3'b110, 8'h80, 8'hFF, lat, rb);
    n_cmp++; if (alu_out !== 8'h00 || overflow !== 1'b0 || zero !== 1'b1) begin
      n_fail++; $display("FAIL rem_min got %h v%b z%b exp 00 v0 z1", alu_out, overflow, zero); end
    drain();
    run_op(3'b101, 8'd100, 8'd7, lat, rb);
    n_cmp++; if (alu_out !== 8'd14) begin n_fail++; $display("FAIL div_pos got %h exp 0e", alu_out); end
    drain();
  endtask

  task automatic test_div_zero();
    int lat; bit rb;
    run_op(3'b101, 8'd5, 8'd0, lat, rb);
    n_cmp++; if (alu_out !== 8'hFF || div_by_zero !== 1'b1 || overflow !== 1'b0 || lat !== 1) begin
      n_fail++; $display("FAIL div0 got %h d%b v%b lat %0d exp ff d1 v0 lat 1", alu_out, div_by_zero, overflow, lat); end
    drain();
    run_op(3'b110, 8'd5, 8'd0, lat, rb);
    n_cmp++; if (alu_out !== 8'h05 || div_by_zero !== 1'b1) begin
      n_fail++; $display("FAIL rem0 got %h d%b exp 05 d1", alu_out, div_by_zero); end
    drain();
    run_op(3'b001, 8'd1, 8'd1, lat, rb);
    n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_clear got %b exp 0", div_by_zero); end
    drain();
  endtask

  task automatic test_back_to_back();
    int lat; bit rb;
    run_op(3'b001, 8'd10, 8'd20, lat, rb);
    for (int i = 0; i < 5; i++) begin
      s_valid = i[0]; bus_a = 8'h70; bus_b = 8'h70; alu_sel = 3'b001;
      #1;
      n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b exp 0", i, s_ready); end
      @(posedge clk); #1;
      n_cmp++; if (alu_out !== 8'h1E || m_valid !== 1'b1 || overflow !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d] got %h m%b v%b exp 1e m1 v0", i, alu_out, m_valid, overflow); end
    end
    s_valid = 1'b1; bus_a = 8'd1; bus_b = 8'd2; alu_sel = 3'b001; m_ready = 1'b1;
    #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b exp 1", s_ready); end
    @(posedge clk); #1;
    s_valid = 1'b0; m_ready = 1'b0;
    n_cmp++; if (alu_out !== 8'h03 || m_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_out got %h m%b exp 03 m1", alu_out, m_valid); end
    drain();
  endtask

  task automatic test_reset_mid();
    int lat; bit rb;
    alu_sel = 3'b011; bus_a = 8'd5; bus_b = 8'd6; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    n_cmp++; if (alu_out !== 8'h00 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_out got %h m%b exp 00 m0", alu_out, m_valid); end
    n_cmp++; if ({zero, negative, overflow, div_by_zero} !== 4'b0 || s_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst_flags got %b r%b exp 0000 r1", {zero, negative, overflow, div_by_zero}, s_ready); end
    @(posedge clk); #1;
    rstn = 1'b1;
    rb = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (m_valid) rb = 1'b1;
    end
    n_cmp++; if (rb !== 1'b0) begin n_fail++; $display("FAIL mid_rst_abort got %b exp 0", rb); end
    run_op(3'b001, 8'd3, 8'd4, lat, rb);
    n_cmp++; if (alu_out !== 8'h07 || lat !== 1) begin
      n_fail++; $display("FAIL post_rst_add got %h lat %0d exp 07 lat 1", alu_out, lat); end
    drain();
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
